// File: rtl/corelet_ctrl.sv
// Corelet instruction sequencer: weight fill/load/flush, activation fill/execute,
// OFIFO drain per kernel position; drives inst[34:0] and SRAM read port.
//
// Ports: clk, reset (sync, active-high), start, mode, l0_full, l0_ready,
//        ofifo_valid -> inst[34:0], xmem_rd, xmem_addr[addr_bw-1:0], busy, done.
module corelet_ctrl #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int len_kij = 9,
  parameter int len_nij = 36,
  parameter int addr_bw = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic               l0_full,
  input  logic               l0_ready,
  input  logic               ofifo_valid,
  output logic [34:0]        inst,
  output logic               xmem_rd,
  output logic [addr_bw-1:0] xmem_addr,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    IDLE, W_FILL, W_LOAD, W_FLUSH,
    A_FILL, A_EXEC, DRAIN, DONE
  } state_t;

  localparam int CW = 16;
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t COL   = CW'(col);
  localparam cnt_t NIJ   = CW'(len_nij);
  localparam cnt_t COL1  = CW'(col - 1);
  localparam cnt_t NIJ1  = CW'(len_nij - 1);
  localparam cnt_t FLS1  = CW'(row + col - 1);
  localparam cnt_t KIJ1  = CW'(len_kij - 1);
  localparam logic [addr_bw-1:0] ABASE =
    {1'b1, {(addr_bw-1){1'b0}}};

  state_t state, state_n;
  cnt_t   kij, kij_n;
  cnt_t   cnt, cnt_n;
  cnt_t   rcnt, rcnt_n;
  logic   pend, pend_n;
  logic   acc, acc_n;
  logic   mode_q, mode_n;

  logic               rd_go;
  logic               ex_go;
  logic               ord_go;
  logic [34:0]        inst_n;
  logic               rd_n;
  logic [addr_bw-1:0] addr_n;
  logic               busy_n;
  logic               done_n;

  // pend: a read was issued last cycle, so L0 sees data now.
  // acc: an OFIFO read was issued last cycle, so SFP sees data now.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      kij       <= '0;
      cnt       <= '0;
      rcnt      <= '0;
      pend      <= 1'b0;
      acc       <= 1'b0;
      mode_q    <= 1'b0;
      inst      <= '0;
      xmem_rd   <= 1'b0;
      xmem_addr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      kij       <= kij_n;
      cnt       <= cnt_n;
      rcnt      <= rcnt_n;
      pend      <= pend_n;
      acc       <= acc_n;
      mode_q    <= mode_n;
      inst      <= inst_n;
      xmem_rd   <= rd_n;
      xmem_addr <= addr_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  always_comb begin
    rd_go  = ((state == W_FILL && cnt < COL) ||
              (state == A_FILL && cnt < NIJ)) && !l0_full;
    ex_go  = (state == A_EXEC) && l0_ready;
    ord_go = (state == DRAIN) && ofifo_valid && (rcnt < NIJ);
  end

  always_comb begin
    state_n = state;
    kij_n   = kij;
    cnt_n   = cnt;
    rcnt_n  = rcnt;
    pend_n  = 1'b0;
    acc_n   = 1'b0;
    mode_n  = mode_q;
    unique case (state)
      IDLE: begin
        if (start) begin
          mode_n  = mode;
          kij_n   = '0;
          cnt_n   = '0;
          rcnt_n  = '0;
          state_n = W_FILL;
        end
      end
      W_FILL: begin
        if (rd_go) begin
          cnt_n  = cnt + CW'(1);
          pend_n = 1'b1;
        end else if (cnt == COL && pend) begin
          cnt_n   = '0;
          state_n = W_LOAD;
        end
      end
      W_LOAD: begin
        if (cnt == COL1) begin
          cnt_n   = '0;
          state_n = W_FLUSH;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      W_FLUSH: begin
        if (cnt == FLS1) begin
          cnt_n   = '0;
          state_n = A_FILL;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      A_FILL: begin
        if (rd_go) begin
          cnt_n  = cnt + CW'(1);
          pend_n = 1'b1;
        end else if (cnt == NIJ && pend) begin
          cnt_n   = '0;
          state_n = A_EXEC;
        end
      end
      A_EXEC: begin
        if (ex_go) begin
          if (cnt == NIJ1) begin
            cnt_n   = '0;
            rcnt_n  = '0;
            state_n = DRAIN;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      DRAIN: begin
        if (ord_go) begin
          rcnt_n = rcnt + CW'(1);
          acc_n  = 1'b1;
        end else if (rcnt == NIJ && acc) begin
          cnt_n  = '0;
          rcnt_n = '0;
          if (kij == KIJ1) begin
            state_n = DONE;
          end else begin
            kij_n   = kij + CW'(1);
            state_n = W_FILL;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
    endcase
  end

  // Outputs are computed for the state being entered and registered,
  // so busy/done line up with the registered state.
  always_comb begin
    inst_n     = '0;
    rd_n       = rd_go;
    addr_n     = xmem_addr;
    busy_n     = (state_n != IDLE);
    done_n     = (state_n == DONE);
    inst_n[0]  = (state == W_LOAD);
    inst_n[1]  = ex_go;
    inst_n[2]  = pend;
    inst_n[3]  = (state == W_LOAD) || ex_go;
    inst_n[6]  = ord_go;
    inst_n[33] = acc;
    inst_n[34] = busy_n && mode_n;
    if (rd_go) begin
      if (state == W_FILL) begin
        addr_n = addr_bw'(kij) * addr_bw'(col)
               + addr_bw'(cnt);
      end else begin
        addr_n = ABASE + addr_bw'(cnt);
      end
    end
    if (state_n == IDLE) begin
      addr_n = '0;
    end
  end

endmodule

// File: doc/corelet_ctrl.md
# corelet_ctrl

Instruction sequencer for one corelet (L0 → MAC array → OFIFO → SFP). On `start` it runs a complete convolution layer of `len_kij` kernel positions, each over `len_nij` output pixels. It drives the corelet's 35-bit instruction word and the weight/activation SRAM read addresses, and it honours L0 and OFIFO flow-control status. It sits between the top-level testbench/host and the corelet.

## Interface
- `row`, default 8: MAC array rows (L0 width in words).
- `col`, default 8: MAC array columns; also the number of weight words per kernel position.
- `len_kij`, default 9: kernel positions per layer.
- `len_nij`, default 36: activation/output pixels per kernel position.
- `addr_bw`, default 11: SRAM address width.

Ports:
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high; returns the block to IDLE.
- `start` in 1: one-cycle request; accepted only in IDLE.
- `mode` in 1: 0 = weight-stationary, 1 = output-stationary. Sampled when `start` is accepted.
- `l0_full` in 1: L0 cannot accept a write this cycle.
- `l0_ready` in 1: L0 holds at least one word.
- `ofifo_valid` in 1: OFIFO holds a complete row readable this cycle.
- `inst` out 35: corelet instruction word (bit map under Operation).
- `xmem_rd` out 1: SRAM read enable. Data arrives one cycle later at the L0 input.
- `xmem_addr` out `addr_bw`: SRAM read address.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the layer completes.

## Operation
- **inst bit map:**
  - [0] kernel load
  - [1] execute
  - [2] l0_wr
  - [3] l0_rd
  - [6] ofifo_rd
  - [33] sfp acc
  - [34] mode_select (latched mode)
  - All other bits are 0.
- **FSM states:** IDLE, W_FILL, W_LOAD, W_FLUSH, A_FILL, A_EXEC, DRAIN, DONE.
- Counters:
  - `kij` counts 0..len_kij-1.
  - `cnt` is the per-phase counter.
  - `rcnt` counts OFIFO reads.
- **IDLE:** all outputs 0. On `start`, latch `mode`, clear `kij` and `cnt`, then go to W_FILL.
- **W_FILL:** each cycle with `l0_full`=0:
  - Assert `xmem_rd` with `xmem_addr` = `kij`*`col` + `cnt`, then increment `cnt`.
  - inst[2] follows `xmem_rd` one cycle later, because SRAM latency is 1.
  - When `l0_full`=1: no read, `cnt` holds.
  - After `col` reads and the final l0_wr: clear `cnt` and go to W_LOAD.
- **W_LOAD:** assert inst[3] and inst[0] for `col` cycles, then go to W_FLUSH.
- **W_FLUSH:** all-zero inst for `row`+`col` cycles to drain the systolic pipeline, then go to A_FILL.
- **A_FILL:** same as W_FILL, with `len_nij` reads at `xmem_addr` = 2^(`addr_bw`-1) + `cnt`. The activation region starts at the upper half of the SRAM. Then go to A_EXEC.
- **A_EXEC:** assert inst[3] and inst[1] for `len_nij` cycles, provided `l0_ready`=1. If `l0_ready`=0, both bits drop and the count holds. Then go to DRAIN.
- **DRAIN:**
  - Each cycle with `ofifo_valid`=1: assert inst[6] and increment `rcnt`.
  - inst[33] is asserted exactly one cycle after each inst[6] (OFIFO read latency is 1). The SFP accumulates each row.
  - When `rcnt` = `len_nij` and the last inst[33] has issued:
    - If `kij` = `len_kij`-1, go to DONE.
    - Otherwise increment `kij`, clear the counters, and go to W_FILL.
- **DONE:** `done`=1 for one cycle, then go to IDLE.
- **Address arithmetic:** unsigned, modulo 2^`addr_bw`. The layer size is the caller's responsibility; the block does not check for overflow.
- **Simultaneous events and reset:**
  - `start` while busy is ignored.
  - `reset` has priority over every other input in every state. In the same edge it forces IDLE, clears all counters, and drives `inst`/`xmem_*`/`busy`/`done` to 0. No partial command is emitted afterwards.

## Timing
- Reset values: `inst`=0, `xmem_rd`=0, `xmem_addr`=0, `busy`=0, `done`=0.
- `busy` rises the cycle after `start` is accepted.
- Outputs are registered; `inst` changes only on clock edges.
- Per-kij cycle count with no stalls: (`col`+1) + `col` + (`row`+`col`) + (`len_nij`+1) + `len_nij` + (`len_nij`+1), plus the DRAIN wait for `ofifo_valid`.
- Layer total: `len_kij` times the per-kij count, plus 1 DONE cycle.
- Stalls (`l0_full`, `l0_ready`, `ofifo_valid`) extend their phase one cycle per stalled cycle. No command bit is lost or duplicated.
- inst[34] holds the latched mode in every non-IDLE cycle.

## Test plan
- Reset, then idle 5 cycles: `inst`=0, `busy`=0, `done`=0 every cycle.
- `start` with `mode`=0, `ofifo_valid` tied 1, no stalls, defaults:
  - `done` pulses at the predicted cycle.
  - 9×8 weight reads at addresses 0..71.
  - 9×36 activation reads at addresses 1024..1059 (repeated each kij).
  - 324 inst[6] pulses.
  - Each inst[33] is one cycle after its inst[6].
- `l0_full` high for 3 cycles mid-W_FILL:
  - `xmem_addr` holds.
  - Exactly 8 l0_wr total per kij.
- `ofifo_valid` toggling every other cycle in DRAIN: inst[6] only when valid; DRAIN exits after exactly 36 reads.
- `reset` asserted during A_EXEC of kij=4:
  - Next cycle `inst`=0 and `busy`=0.
  - A following `start` restarts at kij=0, address 0.
- `start` pulsed while `busy`=1, and `start` with `mode`=1: the repeated `start` has no effect; inst[34]=1 for the whole second run.
